// File: rtl/sram_like_arbiter.sv
// Merges the CPU instruction and data sram-like master ports onto one shared
// slave port. Address phases are arbitrated with fixed data priority, and a
// tag FIFO records the issuing master so that in-order responses are routed back.
module sram_like_arbiter #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned DEPTH_LG = 2
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned CNT_W = DEPTH_LG + 1;

    // Tag per outstanding transaction: 0 = inst, 1 = data
    logic [DEPTH-1:0]    tag_q;
    logic [DEPTH_LG-1:0] wr_ptr_q;
    logic [DEPTH_LG-1:0] rd_ptr_q;
    logic [CNT_W-1:0]    count_q;
    logic [CNT_W-1:0]    count_d;

    logic full;
    logic empty;
    logic gnt_d;
    logic gnt_i;
    logic accept;
    logic pop;
    logic head;

    // FIFO occupancy flags
    always_comb begin
        full  = (count_q == CNT_W'(DEPTH));
        empty = (count_q == CNT_W'(0));
    end

    // Fixed-priority grant: data wins; a full FIFO blocks new address phases
    // even when a response frees a slot this same cycle.
    always_comb begin
        gnt_d   = data_req;
        gnt_i   = inst_req & ~data_req;
        mem_req = (inst_req | data_req) & ~full;
        accept  = mem_req & mem_addr_ok;
    end

    // Request field mux; inst fields are presented when nobody requests
    always_comb begin
        if (gnt_d) begin
            mem_wr    = data_wr;
            mem_size  = data_size;
            mem_addr  = data_addr;
            mem_wdata = data_wdata;
        end else begin
            mem_wr    = inst_wr;
            mem_size  = inst_size;
            mem_addr  = inst_addr;
            mem_wdata = inst_wdata;
        end
    end

    // Address-phase acknowledges back to the masters
    always_comb begin
        data_addr_ok = accept & gnt_d;
        inst_addr_ok = accept & gnt_i;
    end

    // Response routing by head tag; responses while empty are dropped
    always_comb begin
        head         = tag_q[rd_ptr_q];
        pop          = mem_data_ok & ~empty;
        inst_data_ok = pop & ~head;
        data_data_ok = pop & head;
        inst_rdata   = mem_rdata;
        data_rdata   = mem_rdata;
    end

    // Occupancy update; simultaneous accept and pop cancel out
    always_comb begin
        count_d = count_q;
        case ({accept, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers; reset discards all outstanding tags
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (accept) begin
                wr_ptr_q <= wr_ptr_q + DEPTH_LG'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + DEPTH_LG'(1);
            end
            count_q <= count_d;
        end
    end

    // Tag storage; contents are meaningless unless counted, so no reset
    always_ff @(posedge clk) begin
        if (!reset && accept) begin
            tag_q[wr_ptr_q] <= gnt_d;
        end
    end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Self-checking bench for sram_like_arbiter: directed vector table, a
// wraparound sequence, and randomized traffic against a queue-based model.
module tb_sram_like_arbiter;

    localparam int unsigned DEPTH = 4;
    localparam logic [1:0]  ISZ   = 2'd2;
    localparam logic [1:0]  DSZ   = 2'd1;
    localparam logic [31:0] IWD   = 32'h1111_AAAA;
    localparam logic [31:0] DWD   = 32'hDEAD_0000;

    logic        clk;
    logic        reset;
    logic        inst_req, inst_wr;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr, inst_wdata;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_addr_ok, mem_data_ok;
    logic [31:0] mem_rdata;

    int n_chk;
    int n_pass;

    sram_like_arbiter #(.DEPTH(4), .DEPTH_LG(2)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        ir;
        logic [31:0] ia;
        logic        dr;
        logic        dw;
        logic [31:0] da;
        logic        mao;
        logic        mdo;
        logic [31:0] mrd;
        logic        e_req;
        logic        e_wr;
        logic [31:0] e_addr;
        logic        e_iao;
        logic        e_dao;
        logic        e_ido;
        logic        e_ddo;
    } vec_t;

    localparam int NVEC = 26;
    vec_t vecs [NVEC];

    function automatic vec_t mk(logic rst, logic ir, logic [31:0] ia, logic dr, logic dw,
                                logic [31:0] da, logic mao, logic mdo, logic [31:0] mrd,
                                logic e_req, logic e_wr, logic [31:0] e_addr,
                                logic e_iao, logic e_dao, logic e_ido, logic e_ddo);
        vec_t v;
        v.rst = rst; v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da;
        v.mao = mao; v.mdo = mdo; v.mrd = mrd;
        v.e_req = e_req; v.e_wr = e_wr; v.e_addr = e_addr;
        v.e_iao = e_iao; v.e_dao = e_dao; v.e_ido = e_ido; v.e_ddo = e_ddo;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic set_in(input logic rst, input logic ir, input logic iw, input logic [31:0] ia,
                          input logic dr, input logic dw, input logic [31:0] da,
                          input logic mao, input logic mdo, input logic [31:0] mrd);
        reset       = rst;
        inst_req    = ir;  inst_wr = iw;  inst_size = ISZ; inst_addr = ia; inst_wdata = IWD;
        data_req    = dr;  data_wr = dw;  data_size = DSZ; data_addr = da; data_wdata = DWD;
        mem_addr_ok = mao; mem_data_ok = mdo; mem_rdata = mrd;
    endtask

    // Compares every DUT output; size/wdata follow whichever master is granted
    task automatic check_all(input string nm, input logic e_req, input logic e_wr,
                             input logic [31:0] e_addr, input logic e_sel_d,
                             input logic e_iao, input logic e_dao,
                             input logic e_ido, input logic e_ddo, input logic [31:0] e_rd);
        chk({nm, ".mem_req"},      32'(mem_req),      32'(e_req));
        chk({nm, ".mem_wr"},       32'(mem_wr),       32'(e_wr));
        chk({nm, ".mem_addr"},     mem_addr,          e_addr);
        chk({nm, ".mem_size"},     32'(mem_size),     32'(e_sel_d ? DSZ : ISZ));
        chk({nm, ".mem_wdata"},    mem_wdata,         e_sel_d ? DWD : IWD);
        chk({nm, ".inst_addr_ok"}, 32'(inst_addr_ok), 32'(e_iao));
        chk({nm, ".data_addr_ok"}, 32'(data_addr_ok), 32'(e_dao));
        chk({nm, ".inst_data_ok"}, 32'(inst_data_ok), 32'(e_ido));
        chk({nm, ".data_data_ok"}, 32'(data_data_ok), 32'(e_ddo));
        chk({nm, ".inst_rdata"},   inst_rdata,        e_rd);
        chk({nm, ".data_rdata"},   data_rdata,        e_rd);
    endtask

    bit          mq[$];
    logic        r_rst, r_ir, r_iw, r_dr, r_dw, r_mao, r_mdo;
    logic [31:0] r_ia, r_da, r_mrd;
    logic        full, empty, e_req, acc, pop, head;

    initial begin
        n_chk  = 0;
        n_pass = 0;

        // Directed vectors; FIFO contents noted as oldest-first tags
        vecs[0]  = mk(0,1,32'hBFC00000,0,0,32'h0,       1,0,32'h0,      1,0,32'hBFC00000,1,0,0,0);
        vecs[1]  = mk(0,0,32'h0,       0,0,32'h0,       0,0,32'h0,      0,0,32'h0,       0,0,0,0);
        vecs[2]  = mk(0,0,32'h0,       0,0,32'h0,       0,1,32'h3C010000,0,0,32'h0,      0,0,1,0);
        vecs[3]  = mk(0,1,32'hBFC00004,1,1,32'h80001000,1,0,32'h0,      1,1,32'h80001000,0,1,0,0);
        vecs[4]  = mk(0,1,32'hBFC00004,0,0,32'h0,       1,0,32'h0,      1,0,32'hBFC00004,1,0,0,0);
        vecs[5]  = mk(0,0,32'h0,       0,0,32'h0,       0,1,32'h11111111,0,0,32'h0,      0,0,0,1);
        vecs[6]  = mk(0,0,32'h0,       0,0,32'h0,       0,1,32'h22222222,0,0,32'h0,      0,0,1,0);
        vecs[7]  = mk(0,0,32'h0,       1,0,32'h00001000,1,0,32'h0,      1,0,32'h00001000,0,1,0,0);
        vecs[8]  = mk(0,1,32'h00002000,0,0,32'h0,       1,0,32'h0,      1,0,32'h00002000,1,0,0,0);
        vecs[9]  = mk(0,0,32'h0,       1,0,32'h00003000,1,0,32'h0,      1,0,32'h00003000,0,1,0,0);
        vecs[10] = mk(0,1,32'h00004000,0,0,32'h0,       1,0,32'h0,      1,0,32'h00004000,1,0,0,0);
        vecs[11] = mk(0,1,32'h00005000,0,0,32'h0,       1,0,32'h0,      0,0,32'h00005000,0,0,0,0);
        vecs[12] = mk(0,1,32'h00005000,0,0,32'h0,       1,1,32'h33333333,0,0,32'h00005000,0,0,0,1);
        vecs[13] = mk(0,1,32'h00005000,0,0,32'h0,       1,0,32'h0,      1,0,32'h00005000,1,0,0,0);
        vecs[14] = mk(0,0,32'h0,       0,0,32'h0,       0,1,32'h44444444,0,0,32'h0,      0,0,1,0);
        vecs[15] = mk(0,0,32'h0,       0,0,32'h0,       0,1,32'h55555555,0,0,32'h0,      0,0,0,1);
        vecs[16] = mk(0,0,32'h0,       1,0,32'h00006000,1,1,32'h66666666,1,0,32'h00006000,0,1,1,0);
        vecs[17] = mk(0,0,32'h0,       0,0,32'h0,       0,1,32'h77777777,0,0,32'h0,      0,0,1,0);
        vecs[18] = mk(0,0,32'h0,       0,0,32'h0,       0,1,32'h88888888,0,0,32'h0,      0,0,0,1);
        vecs[19] = mk(0,0,32'h0,       0,0,32'h0,       0,1,32'h99999999,0,0,32'h0,      0,0,0,0);
        vecs[20] = mk(0,1,32'h00007000,0,0,32'h0,       1,0,32'h0,      1,0,32'h00007000,1,0,0,0);
        vecs[21] = mk(0,0,32'h0,       1,0,32'h00008000,1,0,32'h0,      1,0,32'h00008000,0,1,0,0);
        vecs[22] = mk(0,1,32'h00009000,0,0,32'h0,       1,0,32'h0,      1,0,32'h00009000,1,0,0,0);
        vecs[23] = mk(1,0,32'h0,       0,0,32'h0,       0,0,32'h0,      0,0,32'h0,       0,0,0,0);
        vecs[24] = mk(0,0,32'h0,       0,0,32'h0,       0,1,32'hAAAAAAAA,0,0,32'h0,      0,0,0,0);
        vecs[25] = mk(0,0,32'h0,       0,0,32'h0,       0,1,32'hBBBBBBBB,0,0,32'h0,      0,0,0,0);

        // Reset, then check idle outputs
        set_in(1, 0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 32'h0);
        repeat (2) @(negedge clk);
        set_in(0, 0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 32'h0);
        #1;
        check_all("reset", 0, 0, 32'h0, 0, 0, 0, 0, 0, 32'h0);
        @(negedge clk);

        for (int i = 0; i < NVEC; i++) begin
            set_in(vecs[i].rst, vecs[i].ir, 1'b0, vecs[i].ia, vecs[i].dr, vecs[i].dw,
                   vecs[i].da, vecs[i].mao, vecs[i].mdo, vecs[i].mrd);
            #1;
            check_all($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_wr, vecs[i].e_addr,
                      vecs[i].dr, vecs[i].e_iao, vecs[i].e_dao, vecs[i].e_ido,
                      vecs[i].e_ddo, vecs[i].mrd);
            @(negedge clk);
        end

        // Back-to-back alternating traffic with one response per cycle (pointer wrap)
        for (int k = 0; k <= 10; k++) begin
            logic ir_k, dr_k, prev_d;
            logic [31:0] a_k;
            ir_k   = (k < 10) && (k % 2 == 0);
            dr_k   = (k < 10) && (k % 2 == 1);
            prev_d = (k > 0) && ((k - 1) % 2 == 1);
            a_k    = 32'h0010_0000 + 32'(k * 4);
            set_in(0, ir_k, 0, ir_k ? a_k : 32'h0, dr_k, 0, dr_k ? a_k : 32'h0,
                   1, (k > 0), 32'hC0DE_0000 + 32'(k));
            #1;
            check_all($sformatf("wrap%0d", k), ir_k | dr_k, 0, (ir_k | dr_k) ? a_k : 32'h0,
                      dr_k, ir_k, dr_k, (k > 0) && !prev_d, prev_d,
                      32'hC0DE_0000 + 32'(k));
            @(negedge clk);
        end

        // Randomized traffic against a queue of outstanding requesters
        mq.delete();
        for (int c = 0; c < 400; c++) begin
            r_rst = ($urandom_range(0, 63) == 0);
            r_ir  = 1'($urandom_range(0, 1));
            r_dr  = ($urandom_range(0, 3) == 0);
            r_iw  = 1'($urandom_range(0, 1));
            r_dw  = 1'($urandom_range(0, 1));
            r_ia  = $urandom;
            r_da  = $urandom;
            r_mao = ($urandom_range(0, 3) != 0);
            r_mdo = ($urandom_range(0, 2) == 0);
            r_mrd = $urandom;
            set_in(r_rst, r_ir, r_iw, r_ia, r_dr, r_dw, r_da, r_mao, r_mdo, r_mrd);

            full  = (mq.size() >= DEPTH);
            empty = (mq.size() == 0);
            e_req = (r_ir | r_dr) && !full;
            acc   = e_req && r_mao;
            pop   = r_mdo && !empty;
            head  = empty ? 1'b0 : mq[0];
            #1;
            check_all($sformatf("rnd%0d", c), e_req, r_dr ? r_dw : r_iw, r_dr ? r_da : r_ia,
                      r_dr, acc && !r_dr, acc && r_dr, pop && !head, pop && head, r_mrd);

            if (r_rst) begin
                mq.delete();
            end else begin
                if (pop) void'(mq.pop_front());
                if (acc) mq.push_back(r_dr);
            end
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
